instr_fetch_unit: RTL

- Front-end fetch stage of the single-issue RISC-V core.
- Owns the program counter and issues word-aligned requests to instruction memory.
- Buffers in-order responses together with their PCs and presents them to the decode stage over a valid/ready handshake.
- Supports redirects (branch/jump/trap), which flush buffered instructions and discard stale in-flight responses.

---
 rtl/processor_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared types and constants for the core front end.
// Fetch entries pair an instruction word with its byte address.
package processor_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy.
// Flush wins over push; a pop in a flush cycle just empties the FIFO.
module fetch_fifo
    import processor_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage; cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers, rewound together on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word requests, buffers responses.
// Redirects flush buffered work and drop responses still in flight.
module instr_fetch_unit
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]    state;
    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW:0]   in_flight;

    logic          req_fire;
    logic          rsp_ok;
    logic          rsp_keep;
    logic          inst_fire;

    fetch_entry_t  ib_head;
    fetch_entry_t  ib_data;
    logic [CW-1:0] ib_count;
    logic          ib_full;
    logic          ib_empty;
    logic          ib_push;

    fetch_entry_t  pq_head;
    fetch_entry_t  pq_data;
    logic [CW-1:0] pq_count;
    logic          pq_full;
    logic          pq_empty;
    logic          unused_ok;

    // Credits cover both in-flight requests and buffered entries,
    // so a response always finds room in the instruction buffer.
    assign in_flight      = {1'b0, outstanding} + {1'b0, ib_count};
    assign imem_req_valid = rst_n
                          && (state == S_FETCH)
                          && !redirect_valid
                          && (in_flight < (CW + 1)'(DEPTH));
    assign imem_req_addr  = pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_ok    = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep  = rsp_ok && (state == S_FETCH) && !redirect_valid;
    assign inst_fire = inst_valid && inst_ready;
    assign drop_next = outstanding - CW'(rsp_ok);

    assign ib_push = rsp_keep && (!ib_full || inst_fire);
    assign ib_data = '{pc: pq_head.pc, instr: imem_rsp_data};
    assign pq_data = '{pc: pc, instr: 32'h0};

    assign inst_valid = !ib_empty;
    assign inst_code  = ib_head.instr;
    assign inst_pc    = ib_head.pc;

    assign unused_ok = ^{pq_count, pq_full, pq_empty,
                         pq_head.instr, redirect_pc[1:0]};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (ib_push),
        .push_data (ib_data),
        .pop       (inst_fire),
        .head      (ib_head),
        .count     (ib_count),
        .full      (ib_full),
        .empty     (ib_empty)
    );

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pq_data),
        .pop       (rsp_keep),
        .head      (pq_head),
        .count     (pq_count),
        .full      (pq_full),
        .empty     (pq_empty)
    );

    // Program counter: advance on accept, jump on redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (req_fire) begin
            pc <= pc + INSTR_BYTES;
        end
    end

    // Requests accepted by memory and not yet answered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
        end
    end

    // Fetch/drain control: stale responses are counted off after a redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? S_DRAIN : S_FETCH;
        end else if ((state == S_DRAIN) && rsp_ok) begin
            drop_cnt <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) begin
                state <= S_FETCH;
            end
        end
    end

endmodule
